// File: rtl/br_multi_xfer_aggregator_rr_pkg.sv
// Shared helpers for the multi-transfer aggregator.
// Only small width-independent utilities live here.
package br_multi_xfer_aggregator_rr_pkg;

  function automatic int unsigned umin(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/br_multi_xfer_aggregator_stage.sv
// Staging buffer: shifts accepted symbols out at index 0 and appends new symbols
// directly above the surviving ones, so pop_data[0..count-1] is always contiguous.
module br_multi_xfer_aggregator_stage #(
  parameter int NumSymbols  = 2,
  parameter int SymbolWidth = 1,
  localparam int CountWidth = $clog2(NumSymbols + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [CountWidth-1:0]                  append_cnt,
  input  logic [NumSymbols-1:0][SymbolWidth-1:0] append_data,
  input  logic [CountWidth-1:0]                  n,
  output logic [CountWidth-1:0]                  count,
  output logic [NumSymbols-1:0][SymbolWidth-1:0] buffer
);

  logic [CountWidth-1:0]                  count_q, count_d;
  logic [CountWidth-1:0]                  base;
  logic [NumSymbols-1:0][SymbolWidth-1:0] buffer_q, buffer_d;

  always_comb begin
    base     = count_q - n;
    count_d  = base + append_cnt;
    buffer_d = buffer_q;
    for (int j = 0; j < NumSymbols; j++) begin
      // Slots vacated by the shift keep stale data; they sit at or above count_d.
      for (int s = 1; s < NumSymbols - j; s++) begin
        if (n == CountWidth'(s)) buffer_d[j] = buffer_q[j + s];
      end
      for (int a = 0; a <= j; a++) begin
        if (base == CountWidth'(j - a) && CountWidth'(a) < append_cnt) begin
          buffer_d[j] = append_data[a];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      buffer_q <= '0;
    end else begin
      count_q  <= count_d;
      buffer_q <= buffer_d;
    end
  end

  assign count  = count_q;
  assign buffer = buffer_q;

endmodule

// File: rtl/br_multi_xfer_aggregator_rr.sv
// Collects symbols from NumFlows ready/valid push flows into a multi-transfer pop
// interface; free slots are handed out by multi-grant round-robin arbitration.
module br_multi_xfer_aggregator_rr
  import br_multi_xfer_aggregator_rr_pkg::*;
#(
  parameter int NumSymbols  = 2,
  parameter int SymbolWidth = 1,
  parameter int NumFlows    = 2,
  localparam int CountWidth = $clog2(NumSymbols + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NumFlows-1:0]                    push_valid,
  output logic [NumFlows-1:0]                    push_ready,
  input  logic [NumFlows-1:0][SymbolWidth-1:0]   push_data,
  output logic [CountWidth-1:0]                  pop_sendable,
  input  logic [CountWidth-1:0]                  pop_receivable,
  output logic [NumSymbols-1:0][SymbolWidth-1:0] pop_data
);

  localparam int PtrWidth = (NumFlows > 1) ? $clog2(NumFlows) : 1;

  if (NumSymbols < 2) begin : g_bad_num_symbols
    $error("NumSymbols must be >= 2");
  end
  if (SymbolWidth < 1) begin : g_bad_symbol_width
    $error("SymbolWidth must be >= 1");
  end
  if (NumFlows < NumSymbols) begin : g_bad_num_flows
    $error("NumFlows must be >= NumSymbols");
  end

  logic [PtrWidth-1:0]                    ptr_q, ptr_d;
  logic [CountWidth-1:0]                  count, n, free, grant_cnt;
  logic [2*NumFlows-1:0]                  valid_dbl, grant_dbl;
  logic [NumFlows-1:0]                    valid_rot, grant_rot, grant;
  logic [2*NumFlows*SymbolWidth-1:0]      data_dbl;
  logic [NumFlows-1:0][SymbolWidth-1:0]   data_rot;
  logic [NumSymbols-1:0][SymbolWidth-1:0] append_data;
  int                                     last_rot;
  int                                     ptr_sum;

  // Rotate so ptr lands at index 0, grant in order, then rotate grants back.
  always_comb begin
    n         = CountWidth'(umin(32'(count), 32'(pop_receivable)));
    free      = CountWidth'(NumSymbols) - count + n;
    valid_dbl = {push_valid, push_valid} >> ptr_q;
    valid_rot = valid_dbl[NumFlows-1:0];
    data_dbl  = {push_data, push_data} >> (int'(ptr_q) * SymbolWidth);
    data_rot  = data_dbl[NumFlows*SymbolWidth-1:0];

    grant_rot   = '0;
    grant_cnt   = '0;
    append_data = '0;
    last_rot    = 0;
    for (int k = 0; k < NumFlows; k++) begin
      if (valid_rot[k] && grant_cnt < free && !rst) begin
        grant_rot[k] = 1'b1;
        for (int j = 0; j < NumSymbols; j++) begin
          if (grant_cnt == CountWidth'(j)) append_data[j] = data_rot[k];
        end
        grant_cnt = grant_cnt + CountWidth'(1);
        last_rot  = k;
      end
    end

    grant_dbl = {grant_rot, grant_rot} << ptr_q;
    grant     = grant_dbl[2*NumFlows-1:NumFlows];

    ptr_sum = int'(ptr_q) + last_rot + 1;
    if (ptr_sum >= NumFlows) ptr_sum = ptr_sum - NumFlows;
    ptr_d = (grant_cnt != '0) ? PtrWidth'(ptr_sum) : ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  br_multi_xfer_aggregator_stage #(
    .NumSymbols (NumSymbols),
    .SymbolWidth(SymbolWidth)
  ) u_stage (
    .clk        (clk),
    .rst        (rst),
    .append_cnt (grant_cnt),
    .append_data(append_data),
    .n          (n),
    .count      (count),
    .buffer     (pop_data)
  );

  assign push_ready   = grant;
  assign pop_sendable = count;

`ifndef SYNTHESIS
  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    count <= CountWidth'(NumSymbols));
  a_ready_le_free: assert property (@(posedge clk) disable iff (rst)
    $countones(push_ready) <= int'(free));

  for (genvar i = 0; i < NumFlows; i++) begin : g_push_proto
    m_push_hold: assume property (@(posedge clk) disable iff (rst)
      push_valid[i] && !push_ready[i] |=> push_valid[i] && $stable(push_data[i]));
  end

  c_full_backpressure: cover property (@(posedge clk) disable iff (rst)
    count == CountWidth'(NumSymbols) && pop_receivable == '0 && push_valid != '0);
  c_wrap_grant: cover property (@(posedge clk) disable iff (rst)
    grant_cnt != '0 && int'(ptr_q) + last_rot >= NumFlows);
  c_partial_xfer: cover property (@(posedge clk) disable iff (rst)
    n != '0 && n < count);
`endif

endmodule

// File: tb/tb_br_multi_xfer_aggregator_rr.sv
// Bench for the round-robin multi-transfer aggregator (4 symbols, 6 flows, 8-bit).
// Directed vector table, hand sequences for backpressure/reset, then a random scoreboard run.
module tb_br_multi_xfer_aggregator_rr;

  localparam int NS = 4;
  localparam int NF = 6;
  localparam int SW = 8;
  localparam int CW = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NF-1:0]          push_valid;
  logic [NF-1:0]          push_ready;
  logic [NF-1:0][SW-1:0]  push_data;
  logic [CW-1:0]          pop_sendable;
  logic [CW-1:0]          pop_receivable;
  logic [NS-1:0][SW-1:0]  pop_data;

  int checks = 0;
  int errors = 0;

  br_multi_xfer_aggregator_rr #(
    .NumSymbols (NS),
    .SymbolWidth(SW),
    .NumFlows   (NF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .push_valid    (push_valid),
    .push_ready    (push_ready),
    .push_data     (push_data),
    .pop_sendable  (pop_sendable),
    .pop_receivable(pop_receivable),
    .pop_data      (pop_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NF-1:0]         valid;
    logic [CW-1:0]         recv;
    logic [NF-1:0]         ready;
    logic [CW-1:0]         cnt;
    logic [NS-1:0][SW-1:0] data;
  } row_t;

  row_t tbl[18];

  logic [SW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Entered and left at posedge+1: drive, check ready, clock, check registered outputs.
  task automatic apply_row(input int i);
    push_valid     = tbl[i].valid;
    pop_receivable = tbl[i].recv;
    #1;
    chk($sformatf("row%0d_ready", i), 64'(push_ready), 64'(tbl[i].ready));
    @(posedge clk); #1;
    chk($sformatf("row%0d_sendable", i), 64'(pop_sendable), 64'(tbl[i].cnt));
    for (int j = 0; j < NS; j++) begin
      if (j < int'(tbl[i].cnt))
        chk($sformatf("row%0d_data%0d", i, j), 64'(pop_data[j]), 64'(tbl[i].data[j]));
    end
  endtask

  task automatic run_random(input int cycles);
    logic [NF-1:0] v;
    logic [SW-1:0] d[NF];
    logic [NF-1:0] exp_ready;
    int seq[NF];
    int wt[NF];
    int m_ptr, sz, n, free, g, last, f;
    logic [CW-1:0] recv;

    rst = 1'b1;
    push_valid = '0;
    pop_receivable = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    m_ptr = 0;
    v = '0;
    for (int i = 0; i < NF; i++) begin
      seq[i] = 0;
      wt[i]  = 0;
      d[i]   = '0;
    end

    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < NF; i++) begin
        if (!v[i] && $urandom_range(0, 2) != 0) begin
          v[i] = 1'b1;
          d[i] = {3'(i), 5'(seq[i])};
        end
        push_data[i] = d[i];
      end
      recv = CW'($urandom_range(0, 5));
      push_valid = v;
      pop_receivable = recv;

      sz   = exp_q.size();
      n    = (sz < int'(recv)) ? sz : int'(recv);
      free = NS - sz + n;
      g    = 0;
      last = 0;
      exp_ready = '0;
      for (int k = 0; k < NF; k++) begin
        f = (m_ptr + k) % NF;
        if (v[f] && g < free) begin
          exp_ready[f] = 1'b1;
          g++;
          last = f;
        end
      end

      #1;
      chk("rand_ready", 64'(push_ready), 64'(exp_ready));
      chk("rand_sendable", 64'(pop_sendable), 64'(sz));
      for (int k = 0; k < n; k++)
        chk("rand_pop_data", 64'(pop_data[k]), 64'(exp_q.pop_front()));

      // Fairness from observed grants: a waiting flow must be served within NF grant events.
      if (push_ready != '0) begin
        for (int i = 0; i < NF; i++) begin
          if (push_ready[i]) begin
            chk("rand_fairness", 64'(wt[i] < NF), 64'd1);
            wt[i] = 0;
          end else if (v[i]) begin
            wt[i]++;
          end
        end
      end

      for (int k = 0; k < NF; k++) begin
        f = (m_ptr + k) % NF;
        if (exp_ready[f]) begin
          exp_q.push_back(d[f]);
          seq[f]++;
          v[f] = 1'b0;
        end
      end
      if (g > 0) m_ptr = (last + 1) % NF;

      @(posedge clk); #1;
    end
  endtask

  initial begin
    tbl[0]  = '{6'h3F, 3'd0, 6'h0F, 3'd4, {8'h13, 8'h12, 8'h11, 8'h10}};
    tbl[1]  = '{6'h3F, 3'd4, 6'h33, 3'd4, {8'h11, 8'h10, 8'h15, 8'h14}};
    tbl[2]  = '{6'h3F, 3'd0, 6'h00, 3'd4, {8'h11, 8'h10, 8'h15, 8'h14}};
    tbl[3]  = '{6'h3F, 3'd1, 6'h04, 3'd4, {8'h12, 8'h11, 8'h10, 8'h15}};
    tbl[4]  = '{6'h3F, 3'd2, 6'h18, 3'd4, {8'h14, 8'h13, 8'h12, 8'h11}};
    tbl[5]  = '{6'h3F, 3'd4, 6'h27, 3'd4, {8'h12, 8'h11, 8'h10, 8'h15}};
    tbl[6]  = '{6'h18, 3'd4, 6'h18, 3'd2, {8'h00, 8'h00, 8'h14, 8'h13}};
    tbl[7]  = '{6'h00, 3'd1, 6'h00, 3'd1, {8'h00, 8'h00, 8'h00, 8'h14}};
    tbl[8]  = '{6'h00, 3'd7, 6'h00, 3'd0, {8'h00, 8'h00, 8'h00, 8'h00}};
    tbl[9]  = '{6'h00, 3'd0, 6'h00, 3'd0, {8'h00, 8'h00, 8'h00, 8'h00}};
    tbl[10] = '{6'h20, 3'd0, 6'h20, 3'd1, {8'h00, 8'h00, 8'h00, 8'h15}};
    tbl[11] = '{6'h03, 3'd0, 6'h03, 3'd3, {8'h00, 8'h11, 8'h10, 8'h15}};
    tbl[12] = '{6'h04, 3'd1, 6'h04, 3'd3, {8'h00, 8'h12, 8'h11, 8'h10}};
    tbl[13] = '{6'h00, 3'd1, 6'h00, 3'd2, {8'h00, 8'h00, 8'h12, 8'h11}};
    tbl[14] = '{6'h3F, 3'd4, 6'h39, 3'd4, {8'h10, 8'h15, 8'h14, 8'h13}};
    tbl[15] = '{6'h3F, 3'd4, 6'h1E, 3'd4, {8'h14, 8'h13, 8'h12, 8'h11}};
    tbl[16] = '{6'h21, 3'd1, 6'h20, 3'd4, {8'h15, 8'h14, 8'h13, 8'h12}};
    tbl[17] = '{6'h01, 3'd2, 6'h01, 3'd3, {8'h00, 8'h10, 8'h15, 8'h14}};

    // Clock/reset: ready must stay low during reset even with every flow valid.
    rst = 1'b1;
    push_valid = 6'h3F;
    pop_receivable = '0;
    for (int i = 0; i < NF; i++) push_data[i] = 8'h10 + 8'(i);
    #1;
    chk("reset_ready", 64'(push_ready), 64'd0);
    chk("reset_sendable", 64'(pop_sendable), 64'd0);
    chk("reset_data", 64'(pop_data), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    push_valid = '0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_sendable", 64'(pop_sendable), 64'd0);
    chk("idle_ready", 64'(push_ready), 64'd0);

    for (int i = 0; i <= 14; i++) apply_row(i);

    // Full buffer with no consumer: nothing may move for 5 cycles.
    push_valid = 6'h3F;
    pop_receivable = '0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_ready", 64'(push_ready), 64'd0);
      @(posedge clk); #1;
      chk("bp_sendable", 64'(pop_sendable), 64'd4);
      chk("bp_data", 64'(pop_data), 64'h10151413);
    end

    for (int i = 15; i <= 17; i++) apply_row(i);

    // Asynchronous reset mid-cycle with count=3.
    push_valid = '0;
    pop_receivable = '0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_sendable", 64'(pop_sendable), 64'd0);
    chk("midrst_data", 64'(pop_data), 64'd0);
    @(posedge clk); #1;
    push_valid = 6'h3F;
    #1;
    chk("midrst_ready_held", 64'(push_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("postrst_ready_ptr0", 64'(push_ready), 64'h0F);
    @(posedge clk); #1;
    chk("postrst_sendable", 64'(pop_sendable), 64'd4);
    chk("postrst_data", 64'(pop_data), 64'h13121110);

    run_random(10000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
